line_fill_demux: RTL
====================

// Module: line_fill_demux
// PURPOSE
//  Write-side counterpart of the cache's 4:1 word-select read path: assembles one
//  4-word cache line from words streamed serially by memory on a refill.
//  Steers each arriving word into its line slot (1:4 demux), critical-word-first
//  with wrap-around, then presents the complete line to the cache data array.
//  Sits between the memory response port and the cache line write port.
// PARAMETERS
//  WORD_W          18   data word width in bits, same as the cache word
//  WORDS_PER_LINE  4    words per line; fixed at 4 (2-bit word offset)
// PORTS
//  clk          in   1         single clock; all state on rising edge
//  rst_n        in   1         asynchronous, active-low reset
//  fill_req     in   1         start a line refill (sampled in IDLE only)
//  fill_offset  in   2         word offset of critical word; first word to arrive
//  fill_busy    out  1         high in FILL and DONE
//  mem_valid    in   1         memory word present on mem_data
//  mem_ready    out  1         block accepts a word this cycle
//  mem_data     in   WORD_W    memory word
//  line_valid   out  1         assembled line available
//  line_data    out  4*WORD_W  slot k at [k*WORD_W +: WORD_W]
//  line_ack     in   1         cache has written the line
//  crit_valid   out  1         critical-word forward strobe (see CONFIGURATION)
//  crit_data    out  WORD_W    critical-word forward data
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; ptr=0; cnt=0; all slots=0; fill_busy=0,
//   mem_ready=0, line_valid=0, crit_valid=0, crit_data=0. Reset mid-fill abandons
//   the line; no partial line_valid ever appears.
//  FSM IDLE -> FILL on fill_req: ptr<=fill_offset, cnt<=0, crit_off<=fill_offset.
//  FILL: mem_ready=1 (combinational from state). Word accepted when
//   mem_valid&&mem_ready: slot[ptr]<=mem_data; ptr<=ptr+1 mod 4 (3 wraps to 0);
//   cnt<=cnt+1. On the acceptance with cnt==3 -> DONE.
//  DONE: line_valid=1, mem_ready=0, line_data stable. line_ack -> IDLE.
//   line_ack and fill_req same cycle in DONE: go directly to FILL (back-to-back
//   refill, new offset latched); line_valid drops the following cycle.
//  fill_req in FILL/DONE (except above) ignored. line_ack outside DONE ignored.
//  mem_valid gaps in FILL: hold state, no slot written.
//  Latency: line_valid rises the cycle after the 4th accepted word; minimum
//   fill_req-to-line_valid = 5 cycles with mem_valid held high.
//  Slots not yet written in the current fill retain previous line's values.
// CONFIGURATION
//  LINE_FILL_CRIT_FWD_EN defined: crit_valid is a 1-cycle registered pulse the
//   cycle after the first word (slot fill_offset) is accepted; crit_data holds
//   that word until the next forward. Lets the CPU restart before line completes.
//  Not defined: crit_valid and crit_data tied to 0; no forwarding registers built.
// STRUCTURE
//  Package cache_fill_pkg: WORD_W, WORDS_PER_LINE, OFF_W=2, state enum
//   {ST_IDLE, ST_FILL, ST_DONE}, slot-slice helper.
//  Sub-module line_slot_dec: 2-to-4 one-hot write-enable decoder (ptr, we -> en[3:0]).
//  Top holds FSM, ptr/cnt counters, 4 slot registers, optional forward register.
// TESTING
//  Offset 0, words A0..A3 back-to-back -> slots {A3,A2,A1,A0}, line_valid at +5.
//  Offset 2, words 11,22,33,44 -> slot2=11,slot3=22,slot0=33,slot1=44 (wrap).
//  Offset 1, mem_valid gaps (1 idle cycle between words) -> same line, no stray
//   writes; mem_ready stays 1 through gaps, drops in DONE.
//  rst_n low after 2 words accepted -> all outputs 0 immediately; next fill clean.
//  DONE with line_ack+fill_req(offset 3) same cycle -> FILL, first word to slot3.
//  With LINE_FILL_CRIT_FWD_EN, offset 2, first word 0x2ABCD -> crit_valid pulse
//   one cycle after acceptance, crit_data=0x2ABCD; without macro crit_valid=0.

Source files
------------

// File: rtl/cache_fill_pkg.sv
// Shared constants, FSM state type and slot helpers for the cache line-fill path.
package cache_fill_pkg;

    localparam int WORD_W         = 18;
    localparam int WORDS_PER_LINE = 4;
    localparam int OFF_W          = 2;
    localparam int LINE_W         = WORD_W * WORDS_PER_LINE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_e;

    // Slot k of a packed line lives at [k*WORD_W +: WORD_W].
    function automatic logic [WORD_W-1:0] get_slot(input logic [LINE_W-1:0] line,
                                                   input logic [OFF_W-1:0]  k);
        return line[k*WORD_W +: WORD_W];
    endfunction

    // Word pointer advances critical-word-first and wraps 3 -> 0.
    function automatic logic [OFF_W-1:0] next_ptr(input logic [OFF_W-1:0] ptr);
        return ptr + 2'd1;
    endfunction

endpackage

// File: rtl/line_slot_dec.sv
// 2-to-4 one-hot write-enable decoder selecting the line slot for an accepted word.
module line_slot_dec
    import cache_fill_pkg::*;
(
    input  logic [OFF_W-1:0]          ptr,
    input  logic                      we,
    output logic [WORDS_PER_LINE-1:0] en
);

    // Decode the slot pointer into a one-hot enable, gated by the write strobe.
    always_comb begin
        en = 4'b0000;
        if (we) begin
            case (ptr)
                2'd0:    en = 4'b0001;
                2'd1:    en = 4'b0010;
                2'd2:    en = 4'b0100;
                2'd3:    en = 4'b1000;
                default: en = 4'b0000;
            endcase
        end else begin
            en = 4'b0000;
        end
    end

endmodule

// File: rtl/line_fill_demux.sv
// Assembles a 4-word cache line from a serial memory refill, critical word first.
// Optional critical-word forwarding is built when LINE_FILL_CRIT_FWD_EN is defined.
module line_fill_demux
    import cache_fill_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fill_req,
    input  logic [OFF_W-1:0]     fill_offset,
    output logic                 fill_busy,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [WORD_W-1:0]    mem_data,
    output logic                 line_valid,
    output logic [LINE_W-1:0]    line_data,
    input  logic                 line_ack,
    output logic                 crit_valid,
    output logic [WORD_W-1:0]    crit_data
);

    fill_state_e               state_r;
    fill_state_e               state_nxt_s;
    logic [OFF_W-1:0]          ptr_r;
    logic [OFF_W-1:0]          cnt_r;
    logic                      accept_s;
    logic                      load_s;
    logic [WORDS_PER_LINE-1:0] slot_en_s;
    logic [WORD_W-1:0]         slot_r [WORDS_PER_LINE];

    // Next-state logic; load_s marks the cycles that latch a new critical offset.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fill_req) begin
                    state_nxt_s = ST_FILL;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (accept_s && (cnt_r == 2'd3)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_DONE: begin
                if (line_ack && fill_req) begin
                    state_nxt_s = ST_FILL;
                    load_s      = 1'b1;
                end else if (line_ack) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign accept_s   = mem_valid && (state_r == ST_FILL);
    assign mem_ready  = (state_r == ST_FILL);
    assign fill_busy  = (state_r == ST_FILL) || (state_r == ST_DONE);
    assign line_valid = (state_r == ST_DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Slot pointer and accepted-word count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= 2'd0;
            cnt_r <= 2'd0;
        end else if (load_s) begin
            ptr_r <= fill_offset;
            cnt_r <= 2'd0;
        end else if (accept_s) begin
            ptr_r <= next_ptr(ptr_r);
            cnt_r <= cnt_r + 2'd1;
        end
    end

    line_slot_dec u_slot_dec (
        .ptr (ptr_r),
        .we  (accept_s),
        .en  (slot_en_s)
    );

    // Slot storage; unwritten slots keep the previous line's contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < WORDS_PER_LINE; k++) begin
                slot_r[k] <= {WORD_W{1'b0}};
            end
        end else begin
            for (int k = 0; k < WORDS_PER_LINE; k++) begin
                if (slot_en_s[k]) begin
                    slot_r[k] <= mem_data;
                end
            end
        end
    end

    // Pack slots onto the line write bus.
    always_comb begin
        line_data = {LINE_W{1'b0}};
        for (int k = 0; k < WORDS_PER_LINE; k++) begin
            line_data[k*WORD_W +: WORD_W] = slot_r[k];
        end
    end

`ifdef LINE_FILL_CRIT_FWD_EN
    logic [OFF_W-1:0]  crit_off_r;
    logic              crit_valid_r;
    logic [WORD_W-1:0] crit_data_r;

    // Capture the critical word on its acceptance and pulse the forward strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crit_off_r   <= 2'd0;
            crit_valid_r <= 1'b0;
            crit_data_r  <= {WORD_W{1'b0}};
        end else begin
            if (load_s) begin
                crit_off_r <= fill_offset;
            end
            if (accept_s && (cnt_r == 2'd0) && (ptr_r == crit_off_r)) begin
                crit_valid_r <= 1'b1;
                crit_data_r  <= mem_data;
            end else begin
                crit_valid_r <= 1'b0;
            end
        end
    end

    assign crit_valid = crit_valid_r;
    assign crit_data  = crit_data_r;
`else
    assign crit_valid = 1'b0;
    assign crit_data  = {WORD_W{1'b0}};
`endif

endmodule
